// File: rtl/restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider_pkg
// Description : Shared types and constants for the restoring divider:
//               FSM state encoding, operand/result widths, iteration count
//               and the overflow sentinel values.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package restoring_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DIVIDEND_W = 12;
   localparam int DIVISOR_W  = 6;
   localparam int QUOT_W     = 6;
   localparam int REM_W      = 7;
   localparam int ITER_COUNT = 6;
   localparam int CNT_W      = 3;

   // Counter value during the final CALC iteration
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

   // Results reported when the quotient cannot be represented
   localparam logic [QUOT_W-1:0] QUOT_OVF = 6'h3F;
   localparam logic [REM_W-1:0]  REM_OVF  = 7'h7F;

endpackage : restoring_divider_pkg
`default_nettype wire

// File: rtl/restoring_divider_dp.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider_dp
// Description : Datapath of the restoring divider. Holds the latched
//               operands, the partial remainder (R) and quotient (Q) shift
//               registers, the trial subtractor with restore mux, and the
//               result registers.
// Ports       : clk, rst (sync, active-low)
//               latch      - capture a_in/b_in into the operand registers
//               load       - initialise R/Q from the latched dividend
//               step       - perform one shift/subtract/restore iteration
//               done       - update quotient/remainder result registers
//               ovf        - with done, write the overflow sentinels instead
//               a_in/b_in  - dividend / divisor operand buses
//               ovf_detect - latched operands give a quotient wider than 6b
//               quotient/remainder - registered results
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider_dp
   import restoring_divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  latch,
   input  logic                  load,
   input  logic                  step,
   input  logic                  done,
   input  logic                  ovf,
   input  logic [DIVIDEND_W-1:0] a_in,
   input  logic [DIVISOR_W-1:0]  b_in,
   output logic                  ovf_detect,
   output logic [QUOT_W-1:0]     quotient,
   output logic [REM_W-1:0]      remainder
);

   logic [DIVIDEND_W-1:0] r_a;
   logic [DIVISOR_W-1:0]  r_b;
   logic [REM_W-1:0]      r_r;
   logic [QUOT_W-1:0]     r_q;
   logic [QUOT_W-1:0]     r_quot;
   logic [REM_W-1:0]      r_rem;

   logic [REM_W-1:0]      w_r_shift;
   logic [REM_W:0]        w_trial;

   // The upper dividend half must be strictly below the divisor for the
   // quotient to fit in six bits; a zero divisor always fails this test.
   assign ovf_detect = (r_b == '0) || (r_a[DIVIDEND_W-1:QUOT_W] >= r_b);

   // Shift the next dividend bit into R. R stays below the divisor between
   // iterations, so R[6] is always zero and may be dropped.
   assign w_r_shift = {r_r[REM_W-2:0], r_q[QUOT_W-1]};
   assign w_trial   = {1'b0, w_r_shift} - {2'b00, r_b};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_r    <= '0;
         r_q    <= '0;
         r_quot <= '0;
         r_rem  <= '0;
      end else begin
         if (latch) begin
            r_a <= a_in;
            r_b <= b_in;
         end

         if (load) begin
            r_r <= {1'b0, r_a[DIVIDEND_W-1:QUOT_W]};
            r_q <= r_a[QUOT_W-1:0];
         end else if (step) begin
            // Negative trial result: keep the shifted remainder (restore)
            if (w_trial[REM_W]) begin
               r_r <= w_r_shift;
            end else begin
               r_r <= w_trial[REM_W-1:0];
            end
            r_q <= {r_q[QUOT_W-2:0], ~w_trial[REM_W]};
         end

         if (done) begin
            if (ovf) begin
               r_quot <= QUOT_OVF;
               r_rem  <= REM_OVF;
            end else begin
               r_quot <= r_q;
               r_rem  <= r_r;
            end
         end
      end
   end

   assign quotient  = r_quot;
   assign remainder = r_rem;

endmodule : restoring_divider_dp
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider
// Description : Sequential unsigned restoring divider, 12-bit dividend by
//               6-bit divisor, one quotient bit per clock. Controller FSM
//               and iteration counter live here; arithmetic is in
//               restoring_divider_dp.
// Ports       : clk       - rising-edge clock
//               rst       - synchronous, active-low reset
//               start     - level request, operands valid while high
//               A_BUS     - unsigned dividend (12b)
//               B_BUS     - unsigned divisor (6b)
//               ready     - idle and able to accept start
//               quotient  - quotient of last completed operation (6b)
//               remainder - remainder of last completed operation (7b)
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider
   import restoring_divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] A_BUS,
   input  logic [DIVISOR_W-1:0]  B_BUS,
   output logic                  ready,
   output logic [QUOT_W-1:0]     quotient,
   output logic [REM_W-1:0]      remainder
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   logic w_latch;
   logic w_load;
   logic w_step;
   logic w_done;
   logic w_arm_exit;
   logic w_ovf_detect;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_cnt <= '0;
         end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
         end
         // Remember whether this operation bypassed CALC so DONE reports
         // the sentinels rather than the stale R/Q contents.
         if (w_arm_exit) begin
            r_ovf <= w_ovf_detect;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      ready      = 1'b0;
      w_latch    = 1'b0;
      w_load     = 1'b0;
      w_step     = 1'b0;
      w_done     = 1'b0;
      w_arm_exit = 1'b0;
      case (r_state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               w_latch = 1'b1;
               w_next  = ARM;
            end
         end
         ARM: begin
            // Waiting for start to drop makes one pulse one operation
            if (!start) begin
               w_arm_exit = 1'b1;
               if (w_ovf_detect) begin
                  w_next = DONE;
               end else begin
                  w_load = 1'b1;
                  w_next = CALC;
               end
            end
         end
         CALC: begin
            w_step = 1'b1;
            if (r_cnt == LAST_ITER) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   restoring_divider_dp u_dp (
      .clk        (clk),
      .rst        (rst),
      .latch      (w_latch),
      .load       (w_load),
      .step       (w_step),
      .done       (w_done),
      .ovf        (r_ovf),
      .a_in       (A_BUS),
      .b_in       (B_BUS),
      .ovf_detect (w_ovf_detect),
      .quotient   (quotient),
      .remainder  (remainder)
   );

endmodule : restoring_divider
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_restoring_divider
// Description : Self-checking bench for restoring_divider. Expected results
//               come from integer division in a reference model, are queued
//               when an operation is issued, and are checked by a monitor
//               each time ready rises.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

   typedef struct packed {
      logic       ovf;
      logic [5:0] q;
      logic [6:0] r;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [11:0] A_BUS;
   logic [5:0]  B_BUS;
   logic        ready;
   logic [5:0]  quotient;
   logic [6:0]  remainder;

   int   total;
   int   bad;
   exp_t sb[$];
   logic prev_ready;

   restoring_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .A_BUS     (A_BUS),
      .B_BUS     (B_BUS),
      .ready     (ready),
      .quotient  (quotient),
      .remainder (remainder)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: quotient must fit in 6 bits, otherwise sentinels
   function automatic exp_t model(input int a, input int b);
      exp_t e;
      if (b == 0 || (a / b) > 63) begin
         e.ovf = 1'b1;
         e.q   = 6'h3F;
         e.r   = 7'h7F;
      end else begin
         e.ovf = 1'b0;
         e.q   = 6'(a / b);
         e.r   = 7'(a % b);
      end
      return e;
   endfunction

   // Monitor: a rising ready marks a completed (or reset-aborted) operation
   initial prev_ready = 1'b1;
   always @(negedge clk) begin
      if (ready === 1'b1 && prev_ready !== 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mon_quotient", int'(quotient), int'(e.q));
            chk("mon_remainder", int'(remainder), int'(e.r));
         end
      end
      prev_ready = ready;
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (ready !== 1'b1) chk("ready_timeout", 0, 1);
   endtask

   // hold: cycles start stays high; change: scramble operands in ARM while
   // start is still high; poke: raise start again during CALC
   task automatic do_op(input int a, input int b, input int hold,
                        input bit change, input bit poke);
      exp_t e;
      int   n;
      wait_ready();
      @(negedge clk);
      A_BUS = 12'(a);
      B_BUS = 6'(b);
      start = 1'b1;
      e = model(a, b);
      sb.push_back(e);
      repeat (hold) @(negedge clk);
      if (change) begin
         A_BUS = 12'd0;
         B_BUS = 6'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      A_BUS = 12'($urandom);
      B_BUS = 6'($urandom);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
         start = poke && !e.ovf && (n == 2 || n == 3);
      end while (ready !== 1'b1 && n < 50);
      start = 1'b0;
      chk("latency", n, e.ovf ? 2 : 8);
      // Results must hold while idle
      repeat (3) @(negedge clk);
      chk("hold_quotient", int'(quotient), int'(e.q));
      chk("hold_remainder", int'(remainder), int'(e.r));
      chk("hold_ready", int'(ready), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int b;
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      start = 1'b1;
      A_BUS = 12'd1050;
      B_BUS = 6'd31;

      // Reset with start asserted: must stay idle with cleared outputs
      repeat (2) @(negedge clk);
      chk("reset_ready", int'(ready), 1);
      chk("reset_quotient", int'(quotient), 0);
      chk("reset_remainder", int'(remainder), 0);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", int'(ready), 1);

      // Directed cases
      do_op(1050, 31, 6, 1'b0, 1'b0);
      do_op(1205, 30, 1, 1'b0, 1'b0);
      do_op(926, 19, 1, 1'b0, 1'b0);
      do_op(843, 21, 1, 1'b0, 1'b0);
      do_op(900, 30, 1, 1'b1, 1'b0);
      do_op(4095, 5, 1, 1'b0, 1'b0);
      do_op(100, 0, 2, 1'b0, 1'b0);
      do_op(4032, 63, 1, 1'b0, 1'b1);
      do_op(4031, 63, 1, 1'b0, 1'b1);
      do_op(0, 1, 1, 1'b0, 1'b0);

      // Reset in the middle of CALC aborts and clears outputs
      wait_ready();
      @(negedge clk);
      A_BUS = 12'd1050;
      B_BUS = 6'd31;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("midop_busy", int'(ready), 0);
      sb.push_back('{ovf: 1'b0, q: 6'd0, r: 7'd0});
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", int'(ready), 1);
      chk("abort_quotient", int'(quotient), 0);
      chk("abort_remainder", int'(remainder), 0);
      rst = 1'b1;
      do_op(1050, 31, 1, 1'b0, 1'b0);

      // Randomized operations, mostly in the representable range
      for (int i = 0; i < 24; i++) begin
         b = int'($urandom_range(0, 63));
         if (b == 0 || $urandom_range(0, 3) == 0) begin
            a = int'($urandom_range(0, 4095));
         end else begin
            a = int'($urandom_range(0, 64 * b - 1));
         end
         do_op(a, b, int'($urandom_range(1, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_restoring_divider
`default_nettype wire
